// File: rtl/svdb_row_batcher.sv
// svdb_row_batcher: buffers tagged records in a circular FIFO and re-emits
// them as framed batches (BEGIN, ROW..., COMMIT) with monotonically
// increasing row ids. Batches close on BATCH_MAX rows, on an idle timeout,
// or on a flush request once the FIFO has drained.
module svdb_row_batcher #(
  parameter int DATA_W    = 64,
  parameter int TAG_W     = 8,
  parameter int DEPTH     = 16,
  parameter int BATCH_MAX = 8,
  parameter int TIMEOUT   = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_kind,
  output logic [31:0]              out_row_id,
  output logic [TAG_W-1:0]         out_tag,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BATCH_W = $clog2(BATCH_MAX + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] KIND_ROW    = 2'd0;
  localparam logic [1:0] KIND_BEGIN  = 2'd1;
  localparam logic [1:0] KIND_COMMIT = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_BEGIN, S_ROWS, S_COMMIT} state_t;

  // Row ids skip zero: the consumer treats id 0 as "no row".
  function automatic logic [31:0] next_row_id(input logic [31:0] id);
    if (id == 32'hFFFF_FFFF) begin
      next_row_id = 32'd1;
    end else begin
      next_row_id = id + 32'd1;
    end
  endfunction

  logic [TAG_W+DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]        count_r, count_next_s;
  state_t                  state_r, state_next_s;
  logic [31:0]             row_id_r, row_id_next_s;
  logic [BATCH_W-1:0]      batch_cnt_r, batch_cnt_next_s;
  logic [IDLE_W-1:0]       idle_cnt_r, idle_cnt_next_s;
  logic                    flush_pend_r, flush_pend_next_s;
  logic                    push_s, pop_s;
  logic [TAG_W-1:0]        head_tag_s;
  logic [DATA_W-1:0]       head_data_s;

  assign in_ready = (count_r != CNT_W'(DEPTH));
  assign level    = count_r;
  assign push_s   = in_valid && in_ready;
  assign pop_s    = (state_r == S_ROWS) && (count_r != CNT_W'(0)) && out_ready;
  assign {head_tag_s, head_data_s} = mem_r[rd_ptr_r];

  // FIFO storage: contents need no reset, occupancy is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_tag, in_data};
    end
  end

  // Occupancy update: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Batch framing: next state, counters, row id and pending-flush flag.
  always_comb begin
    state_next_s      = state_r;
    row_id_next_s     = row_id_r;
    batch_cnt_next_s  = batch_cnt_r;
    idle_cnt_next_s   = idle_cnt_r;
    flush_pend_next_s = flush_pend_r;
    case (state_r)
      // Leaving IDLE on the incoming push as well lets BEGIN appear in the
      // same cycle the first record becomes visible in the FIFO.
      S_IDLE: begin
        if ((count_r != CNT_W'(0)) || push_s) begin
          state_next_s = S_BEGIN;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_BEGIN: begin
        if (out_ready) begin
          state_next_s     = S_ROWS;
          batch_cnt_next_s = BATCH_W'(0);
          idle_cnt_next_s  = IDLE_W'(0);
        end else begin
          state_next_s = S_BEGIN;
        end
      end
      S_ROWS: begin
        if (pop_s) begin
          row_id_next_s    = next_row_id(row_id_r);
          batch_cnt_next_s = batch_cnt_r + BATCH_W'(1);
          idle_cnt_next_s  = IDLE_W'(0);
          if (batch_cnt_r == BATCH_W'(BATCH_MAX - 1)) begin
            state_next_s = S_COMMIT;
          end else begin
            state_next_s = S_ROWS;
          end
        end else if (count_r == CNT_W'(0)) begin
          if (flush_pend_r) begin
            state_next_s = S_COMMIT;
          end else begin
            idle_cnt_next_s = idle_cnt_r + IDLE_W'(1);
            if (idle_cnt_r == IDLE_W'(TIMEOUT - 1)) begin
              state_next_s = S_COMMIT;
            end else begin
              state_next_s = S_ROWS;
            end
          end
        end else begin
          state_next_s = S_ROWS;
        end
      end
      S_COMMIT: begin
        if (out_ready) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_COMMIT;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
    // A flush coinciding with the COMMIT handshake only survives if rows
    // remain for the next batch; an idle, empty batcher ignores flush.
    if ((state_r == S_COMMIT) && out_ready) begin
      flush_pend_next_s = flush && (count_next_s != CNT_W'(0));
    end else if (flush && ((state_r != S_IDLE) || (count_r != CNT_W'(0)))) begin
      flush_pend_next_s = 1'b1;
    end else begin
      flush_pend_next_s = flush_pend_r;
    end
  end

  // Token presentation: all fields decode from registered state and FIFO head.
  always_comb begin
    out_valid  = 1'b0;
    out_kind   = KIND_ROW;
    out_row_id = 32'd0;
    out_tag    = '0;
    out_data   = '0;
    case (state_r)
      S_BEGIN: begin
        out_valid = 1'b1;
        out_kind  = KIND_BEGIN;
      end
      S_ROWS: begin
        if (count_r != CNT_W'(0)) begin
          out_valid  = 1'b1;
          out_row_id = row_id_r;
          out_tag    = head_tag_s;
          out_data   = head_data_s;
        end else begin
          out_valid = 1'b0;
        end
      end
      S_COMMIT: begin
        out_valid = 1'b1;
        out_kind  = KIND_COMMIT;
      end
      default: out_valid = 1'b0;
    endcase
  end

  // State, pointers and counters; reset discards the FIFO and any open batch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      wr_ptr_r     <= PTR_W'(0);
      rd_ptr_r     <= PTR_W'(0);
      count_r      <= CNT_W'(0);
      row_id_r     <= 32'd1;
      batch_cnt_r  <= BATCH_W'(0);
      idle_cnt_r   <= IDLE_W'(0);
      flush_pend_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      count_r      <= count_next_s;
      row_id_r     <= row_id_next_s;
      batch_cnt_r  <= batch_cnt_next_s;
      idle_cnt_r   <= idle_cnt_next_s;
      flush_pend_r <= flush_pend_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_svdb_row_batcher.sv
// Bench for svdb_row_batcher: table-driven first batch, then scoreboarded
// sequences for multi-batch, back-pressure, flush, id wrap and reset.
module tb_svdb_row_batcher;

  localparam int BATCH_MAX = 8;
  localparam int TIMEOUT   = 256;
  localparam logic [1:0] K_ROW = 2'd0, K_BEGIN = 2'd1, K_COMMIT = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0]  in_tag, out_tag;
  logic [63:0] in_data, out_data;
  logic [1:0]  out_kind;
  logic [31:0] out_row_id;
  logic [4:0]  level;

  svdb_row_batcher #(.DATA_W(64), .TAG_W(8), .DEPTH(16), .BATCH_MAX(BATCH_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_row_id(out_row_id), .out_tag(out_tag), .out_data(out_data),
    .level(level)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] kind; logic [31:0] id; logic [7:0] tag; logic [63:0] data; } tok_t;
  typedef struct { logic [7:0] tag; logic [63:0] data; logic [31:0] exp_id; } vec_t;

  tok_t  exp_q[$];
  vec_t  tbl[8];
  int    errors = 0, checks = 0;
  int    cyc = 0, hs_count = 0;
  int    begin_cyc = 0, last_row_cyc = 0, last_commit_cyc = 0;
  logic [31:0] m_id = 32'd1;
  int    m_open = 0;

  // Cycle counter used to time token handshakes.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model of batch framing for uninterrupted streams.
  task automatic model_push(input logic [7:0] tag, input logic [63:0] data);
    if (m_open == 0) exp_q.push_back('{K_BEGIN, 32'd0, 8'd0, 64'd0});
    exp_q.push_back('{K_ROW, m_id, tag, data});
    m_id = (m_id == 32'hFFFF_FFFF) ? 32'd1 : m_id + 32'd1;
    m_open++;
    if (m_open == BATCH_MAX) begin
      exp_q.push_back('{K_COMMIT, 32'd0, 8'd0, 64'd0});
      m_open = 0;
    end
  endtask

  task automatic model_close();
    if (m_open != 0) exp_q.push_back('{K_COMMIT, 32'd0, 8'd0, 64'd0});
    m_open = 0;
  endtask

  task automatic drive_rec(input logic [7:0] tag, input logic [63:0] data);
    int n = 0;
    in_valid = 1'b1; in_tag = tag; in_data = data;
    while (!in_ready && n < 2000) begin tick(); n++; end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready low for %0d cycles, expected acceptance", n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic push_rec(input logic [7:0] tag, input logic [63:0] data);
    drive_rec(tag, data);
    model_push(tag, data);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin tick(); n++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d tokens pending after %0d cycles, expected 0", name, exp_q.size(), n);
    end
    repeat (3) tick();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    m_id = 32'd1;
    m_open = 0;
    tick();
  endtask

  // Scoreboard monitor: every token handshake pops and compares one expectation.
  initial begin
    tok_t t;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_token: got kind=%0d id=%0h tag=%0h, expected none", out_kind, out_row_id, out_tag);
        end else begin
          t = exp_q.pop_front();
          check("tok_kind", 64'(out_kind), 64'(t.kind));
          check("tok_row_id", 64'(out_row_id), 64'(t.id));
          check("tok_tag", 64'(out_tag), 64'(t.tag));
          check("tok_data", out_data, t.data);
        end
        if (out_kind == K_BEGIN) begin_cyc = cyc;
        if (out_kind == K_ROW) last_row_cyc = cyc;
        if (out_kind == K_COMMIT) last_commit_cyc = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] first_id;
    rst = 1'b1; in_valid = 1'b0; in_tag = 8'd0; in_data = 64'd0; flush = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) tbl[i] = '{8'(i + 1), 64'(16 + i), 32'(i + 1)};

    // Reset values.
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_kind", 64'(out_kind), 64'd0);
    check("rst_out_row_id", 64'(out_row_id), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_level", 64'(level), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Table-driven full batch: 10 tokens in 10 cycles.
    out_ready = 1'b1;
    exp_q.push_back('{K_BEGIN, 32'd0, 8'd0, 64'd0});
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{K_ROW, tbl[i].exp_id, tbl[i].tag, tbl[i].data});
      drive_rec(tbl[i].tag, tbl[i].data);
    end
    exp_q.push_back('{K_COMMIT, 32'd0, 8'd0, 64'd0});
    wait_drain("full_batch", 100);
    check("full_batch_cycles", 64'(last_commit_cyc - begin_cyc), 64'd9);

    // 20 records: batches of 8, 8, 4; last closes on timeout.
    reset_dut();
    for (int i = 0; i < 20; i++) push_rec(8'(i + 1), 64'h100 + 64'(i));
    model_close();
    wait_drain("three_batches", 1000);
    check("timeout_gap", 64'(last_commit_cyc - last_row_cyc), 64'(TIMEOUT + 1));

    // Back-pressure: fill FIFO, hold stalled, then drain.
    out_ready = 1'b0;
    first_id = m_id;
    for (int i = 0; i < 16; i++) push_rec(8'h30 + 8'(i), 64'hCAFE_0000 + 64'(i));
    check("full_level", 64'(level), 64'd16);
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_tag = 8'hEE; in_data = 64'hDEAD;
    repeat (3) tick();
    in_valid = 1'b0;
    check("full_level_hold", 64'(level), 64'd16);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_kind", 64'(out_kind), 64'(K_ROW));
      check("stall_row_id", 64'(out_row_id), 64'(first_id));
      check("stall_tag", 64'(out_tag), 64'h30);
      check("stall_data", out_data, 64'hCAFE_0000);
      tick();
    end
    out_ready = 1'b1;
    wait_drain("backpressure_drain", 200);

    // Flush: commit right after the FIFO drains.
    for (int i = 0; i < 3; i++) push_rec(8'h50 + 8'(i), 64'h5000 + 64'(i));
    pulse_flush();
    model_close();
    wait_drain("flush_batch", 100);
    check("flush_gap", 64'(last_commit_cyc - last_row_cyc), 64'd2);

    // Flush while idle and empty: no tokens, nothing left pending.
    pulse_flush();
    repeat (10) tick();
    check("idle_flush_valid", 64'(out_valid), 64'd0);
    check("idle_flush_level", 64'(level), 64'd0);
    push_rec(8'h60, 64'h6000);
    model_close();
    wait_drain("after_idle_flush", 400);
    check("after_idle_flush_gap", 64'(last_commit_cyc - last_row_cyc), 64'(TIMEOUT + 1));

    // Row id wrap skips zero.
    force dut.row_id_r = 32'hFFFF_FFFE;
    tick();
    release dut.row_id_r;
    m_id = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) push_rec(8'h70 + 8'(i), 64'h7000 + 64'(i));
    pulse_flush();
    model_close();
    wait_drain("row_id_wrap", 100);

    // Reset mid-batch after BEGIN and two ROWs.
    base = hs_count;
    for (int i = 0; i < 4; i++) push_rec(8'h80 + 8'(i), 64'h8000 + 64'(i));
    check("pre_rst_handshakes", 64'(hs_count - base), 64'd3);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_level", 64'(level), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    m_id = 32'd1;
    m_open = 0;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) push_rec(8'h90 + 8'(i), 64'h9000 + 64'(i));
    pulse_flush();
    model_close();
    wait_drain("post_rst_batch", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
